// File: rtl/vx_dvstack_ctl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vx_dvstack_ctl_pkg
// Brief    : Shared sizing, stack-entry and split/join command types
// Revision : 1.0
// ============================================================================
package vx_dvstack_ctl_pkg;

    localparam int NUM_WARPS      = 4;
    localparam int NUM_THREADS    = 4;
    localparam int PC_BITS        = 30;
    localparam int DEPTH          = 4;
    localparam int NW_WIDTH       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int DV_STACK_SIZEW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [NUM_THREADS-1:0] orig_tmask;
        logic [NUM_THREADS-1:0] else_tmask;
        logic [PC_BITS-1:0]     else_pc;
        logic                   else_done;
    } dvstack_entry_t;

    typedef struct packed {
        logic                   valid;
        logic                   is_dvg;
        logic [NUM_THREADS-1:0] then_tmask;
        logic [NUM_THREADS-1:0] else_tmask;
        logic [PC_BITS-1:0]     next_pc;
    } split_t;

    typedef struct packed {
        logic                      valid;
        logic [DV_STACK_SIZEW-1:0] stack_ptr;
    } join_t;

endpackage
`default_nettype wire

// File: rtl/vx_dvstack_bank.sv
`default_nettype none
// ============================================================================
// Module   : vx_dvstack_bank
// Brief    : One warp's IPDOM stack: storage, pointer, push/toggle/pop, top read
// Revision : 1.0
// ============================================================================
module vx_dvstack_bank
    import vx_dvstack_ctl_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_push,
    input  dvstack_entry_t            i_push_entry,
    input  logic                      i_toggle,
    input  logic                      i_pop,
    output logic [DV_STACK_SIZEW-1:0] o_ptr,
    output dvstack_entry_t            o_top
);

    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    dvstack_entry_t            r_entries [DEPTH];
    logic [DV_STACK_SIZEW-1:0] r_ptr;

    logic [DV_STACK_SIZEW-1:0] w_top_ptr;
    logic [IDXW-1:0]           w_push_idx;
    logic [IDXW-1:0]           w_top_idx;

    // Caller guarantees push only below DEPTH and toggle/pop only above zero.
    assign w_top_ptr  = r_ptr - DV_STACK_SIZEW'(1);
    assign w_push_idx = r_ptr[IDXW-1:0];
    assign w_top_idx  = w_top_ptr[IDXW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else if (i_push) begin
            r_entries[w_push_idx] <= i_push_entry;
            r_ptr                 <= r_ptr + DV_STACK_SIZEW'(1);
        end else if (i_toggle) begin
            r_entries[w_top_idx].else_done <= 1'b1;
        end else if (i_pop) begin
            r_ptr <= w_top_ptr;
        end
    end

    assign o_ptr = r_ptr;
    assign o_top = r_entries[w_top_idx];

endmodule
`default_nettype wire

// File: rtl/vx_dvstack_ctl.sv
`default_nettype none
// ============================================================================
// Module   : vx_dvstack_ctl
// Brief    : Per-warp divergence stack manager for split/join warp control
// Revision : 1.0
// ============================================================================
module vx_dvstack_ctl
    import vx_dvstack_ctl_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ctl_valid,
    input  logic [NW_WIDTH-1:0]       ctl_wid,
    input  logic                      split_valid,
    input  logic                      split_is_dvg,
    input  logic [NUM_THREADS-1:0]    split_then_tmask,
    input  logic [NUM_THREADS-1:0]    split_else_tmask,
    input  logic [PC_BITS-1:0]        split_next_pc,
    input  logic                      join_valid,
    input  logic [DV_STACK_SIZEW-1:0] join_stack_ptr,
    input  logic [NUM_THREADS-1:0]    cur_tmask,
    input  logic [NW_WIDTH-1:0]       dvstack_wid,
    output logic [DV_STACK_SIZEW-1:0] dvstack_ptr,
    output logic                      tmask_upd_valid,
    output logic [NW_WIDTH-1:0]       tmask_upd_wid,
    output logic [NUM_THREADS-1:0]    tmask_upd_mask,
    output logic                      branch_valid,
    output logic [NW_WIDTH-1:0]       branch_wid,
    output logic [PC_BITS-1:0]        branch_pc,
    output logic                      ovf_err,
    output logic                      unf_err
);

    localparam logic [DV_STACK_SIZEW-1:0] c_DEPTH_PTR = DV_STACK_SIZEW'(DEPTH);

    split_t                    w_split;
    join_t                     w_join;
    logic [DV_STACK_SIZEW-1:0] w_ptr [NUM_WARPS];
    dvstack_entry_t            w_top [NUM_WARPS];
    logic [DV_STACK_SIZEW-1:0] w_cur_ptr;
    dvstack_entry_t            w_cur_top;
    dvstack_entry_t            w_push_entry;

    logic                      w_push, w_toggle, w_pop;
    logic                      w_upd_valid, w_br_valid;
    logic [NUM_THREADS-1:0]    w_upd_mask;
    logic                      w_set_ovf, w_set_unf;

    logic                      r_tmask_upd_valid;
    logic [NW_WIDTH-1:0]       r_tmask_upd_wid;
    logic [NUM_THREADS-1:0]    r_tmask_upd_mask;
    logic                      r_branch_valid;
    logic [NW_WIDTH-1:0]       r_branch_wid;
    logic [PC_BITS-1:0]        r_branch_pc;
    logic                      r_ovf_err;
    logic                      r_unf_err;

    assign w_split = '{valid: ctl_valid & split_valid, is_dvg: split_is_dvg,
                       then_tmask: split_then_tmask, else_tmask: split_else_tmask,
                       next_pc: split_next_pc};
    assign w_join  = '{valid: ctl_valid & join_valid, stack_ptr: join_stack_ptr};

    generate
        for (genvar g = 0; g < NUM_WARPS; g++) begin : g_bank
            vx_dvstack_bank u_bank (
                .clk          (clk),
                .rst          (reset),
                .i_push       (w_push   && (ctl_wid == NW_WIDTH'(g))),
                .i_push_entry (w_push_entry),
                .i_toggle     (w_toggle && (ctl_wid == NW_WIDTH'(g))),
                .i_pop        (w_pop    && (ctl_wid == NW_WIDTH'(g))),
                .o_ptr        (w_ptr[g]),
                .o_top        (w_top[g])
            );
        end
    endgenerate

    assign dvstack_ptr  = w_ptr[dvstack_wid];
    assign w_cur_ptr    = w_ptr[ctl_wid];
    assign w_cur_top    = w_top[ctl_wid];
    assign w_push_entry = '{orig_tmask: cur_tmask, else_tmask: w_split.else_tmask,
                            else_pc: w_split.next_pc, else_done: 1'b0};

    // Split has priority; a join arriving alongside it is dropped and flagged.
    always_comb begin
        w_push      = 1'b0;
        w_toggle    = 1'b0;
        w_pop       = 1'b0;
        w_upd_valid = 1'b0;
        w_upd_mask  = '0;
        w_br_valid  = 1'b0;
        w_set_ovf   = 1'b0;
        w_set_unf   = 1'b0;
        if (w_split.valid) begin
            w_set_unf = w_join.valid;
            if (w_split.is_dvg) begin
                if (w_cur_ptr < c_DEPTH_PTR) begin
                    w_push      = 1'b1;
                    w_upd_valid = 1'b1;
                    w_upd_mask  = w_split.then_tmask;
                end else begin
                    w_set_ovf = 1'b1;
                end
            end
        end else if (w_join.valid) begin
            if (w_join.stack_ptr > w_cur_ptr) begin
                w_set_unf = 1'b1;
            end else if (w_join.stack_ptr < w_cur_ptr) begin
                w_upd_valid = 1'b1;
                if (w_cur_top.else_done) begin
                    w_pop      = 1'b1;
                    w_upd_mask = w_cur_top.orig_tmask;
                end else begin
                    w_toggle   = 1'b1;
                    w_br_valid = 1'b1;
                    w_upd_mask = w_cur_top.else_tmask;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmask_upd_valid <= 1'b0;
            r_tmask_upd_wid   <= '0;
            r_tmask_upd_mask  <= '0;
            r_branch_valid    <= 1'b0;
            r_branch_wid      <= '0;
            r_branch_pc       <= '0;
            r_ovf_err         <= 1'b0;
            r_unf_err         <= 1'b0;
        end else begin
            r_tmask_upd_valid <= w_upd_valid;
            r_branch_valid    <= w_br_valid;
            if (w_upd_valid) begin
                r_tmask_upd_wid  <= ctl_wid;
                r_tmask_upd_mask <= w_upd_mask;
            end
            if (w_br_valid) begin
                r_branch_wid <= ctl_wid;
                r_branch_pc  <= w_cur_top.else_pc;
            end
            r_ovf_err <= r_ovf_err | w_set_ovf;
            r_unf_err <= r_unf_err | w_set_unf;
        end
    end

    assign tmask_upd_valid = r_tmask_upd_valid;
    assign tmask_upd_wid   = r_tmask_upd_wid;
    assign tmask_upd_mask  = r_tmask_upd_mask;
    assign branch_valid    = r_branch_valid;
    assign branch_wid      = r_branch_wid;
    assign branch_pc       = r_branch_pc;
    assign ovf_err         = r_ovf_err;
    assign unf_err         = r_unf_err;

endmodule
`default_nettype wire

// File: tb/tb_vx_dvstack_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vx_dvstack_ctl
// Brief    : Self-checking bench for vx_dvstack_ctl against a stack-of-records model
// Revision : 1.0
// ============================================================================
module tb_vx_dvstack_ctl;
    import vx_dvstack_ctl_pkg::*;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      ctl_valid;
    logic [NW_WIDTH-1:0]       ctl_wid;
    logic                      split_valid;
    logic                      split_is_dvg;
    logic [NUM_THREADS-1:0]    split_then_tmask;
    logic [NUM_THREADS-1:0]    split_else_tmask;
    logic [PC_BITS-1:0]        split_next_pc;
    logic                      join_valid;
    logic [DV_STACK_SIZEW-1:0] join_stack_ptr;
    logic [NUM_THREADS-1:0]    cur_tmask;
    logic [NW_WIDTH-1:0]       dvstack_wid;
    logic [DV_STACK_SIZEW-1:0] dvstack_ptr;
    logic                      tmask_upd_valid;
    logic [NW_WIDTH-1:0]       tmask_upd_wid;
    logic [NUM_THREADS-1:0]    tmask_upd_mask;
    logic                      branch_valid;
    logic [NW_WIDTH-1:0]       branch_wid;
    logic [PC_BITS-1:0]        branch_pc;
    logic                      ovf_err;
    logic                      unf_err;

    always #5 clk = ~clk;

    vx_dvstack_ctl dut (
        .clk              (clk),
        .reset            (reset),
        .ctl_valid        (ctl_valid),
        .ctl_wid          (ctl_wid),
        .split_valid      (split_valid),
        .split_is_dvg     (split_is_dvg),
        .split_then_tmask (split_then_tmask),
        .split_else_tmask (split_else_tmask),
        .split_next_pc    (split_next_pc),
        .join_valid       (join_valid),
        .join_stack_ptr   (join_stack_ptr),
        .cur_tmask        (cur_tmask),
        .dvstack_wid      (dvstack_wid),
        .dvstack_ptr      (dvstack_ptr),
        .tmask_upd_valid  (tmask_upd_valid),
        .tmask_upd_wid    (tmask_upd_wid),
        .tmask_upd_mask   (tmask_upd_mask),
        .branch_valid     (branch_valid),
        .branch_wid       (branch_wid),
        .branch_pc        (branch_pc),
        .ovf_err          (ovf_err),
        .unf_err          (unf_err)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: each warp owns a list of pushed records; depth is the list length.
    int       m_ptr  [NUM_WARPS];
    bit [3:0] m_orig [NUM_WARPS][DEPTH];
    bit [3:0] m_else [NUM_WARPS][DEPTH];
    bit [29:0] m_pc  [NUM_WARPS][DEPTH];
    bit       m_done [NUM_WARPS][DEPTH];

    bit        armed = 1'b0;
    bit        e_tv, e_bv, e_ovf, e_unf;
    int        e_tw, e_bw;
    bit [3:0]  e_tm;
    bit [29:0] e_bpc;

    always @(negedge clk) begin
        if (armed) begin
            chk("tmask_upd_valid", tmask_upd_valid, e_tv);
            chk("branch_valid", branch_valid, e_bv);
            chk("ovf_err", ovf_err, e_ovf);
            chk("unf_err", unf_err, e_unf);
            if (e_tv) begin
                chk("tmask_upd_wid", tmask_upd_wid, e_tw);
                chk("tmask_upd_mask", tmask_upd_mask, e_tm);
            end
            if (e_bv) begin
                chk("branch_wid", branch_wid, e_bw);
                chk("branch_pc", branch_pc, e_bpc);
            end
        end
    end

    task automatic step(bit rst, bit v, int w, bit sv, bit dvg, bit [3:0] th, bit [3:0] el,
                        bit [29:0] pc, bit jv, int jsp, bit [3:0] cur);
        bit n_tv, n_bv;
        bit [3:0] n_tm;
        bit [29:0] n_bpc;
        int t;
        n_tv = 0; n_bv = 0; n_tm = 0; n_bpc = 0;
        reset = rst; ctl_valid = v; ctl_wid = NW_WIDTH'(w);
        split_valid = sv; split_is_dvg = dvg; split_then_tmask = th;
        split_else_tmask = el; split_next_pc = pc; join_valid = jv;
        join_stack_ptr = DV_STACK_SIZEW'(jsp); cur_tmask = cur;
        dvstack_wid = NW_WIDTH'(w);
        #1 chk("dvstack_ptr", dvstack_ptr, m_ptr[w]);
        if (rst) begin
            for (int i = 0; i < NUM_WARPS; i++) begin
                m_ptr[i] = 0;
                for (int j = 0; j < DEPTH; j++) m_done[i][j] = 0;
            end
            e_ovf = 0; e_unf = 0;
        end else if (v && sv) begin
            if (jv) e_unf = 1;
            if (dvg) begin
                if (m_ptr[w] == DEPTH) e_ovf = 1;
                else begin
                    t = m_ptr[w];
                    m_orig[w][t] = cur; m_else[w][t] = el; m_pc[w][t] = pc; m_done[w][t] = 0;
                    m_ptr[w] = t + 1;
                    n_tv = 1; n_tm = th;
                end
            end
        end else if (v && jv) begin
            if (jsp > m_ptr[w]) e_unf = 1;
            else if (jsp < m_ptr[w]) begin
                t = m_ptr[w] - 1;
                n_tv = 1;
                if (!m_done[w][t]) begin
                    m_done[w][t] = 1; n_tm = m_else[w][t]; n_bv = 1; n_bpc = m_pc[w][t];
                end else begin
                    m_ptr[w] = t; n_tm = m_orig[w][t];
                end
            end
        end
        @(posedge clk);
        e_tv = n_tv; e_tm = n_tm; e_tw = w; e_bv = n_bv; e_bpc = n_bpc; e_bw = w;
        armed = 1'b1;
        @(negedge clk);
    endtask

    task automatic split(int w, bit dvg, bit [3:0] cur, bit [3:0] th, bit [3:0] el, bit [29:0] pc);
        step(0, 1, w, 1, dvg, th, el, pc, 0, 0, cur);
    endtask

    task automatic joinc(int w, int jsp);
        step(0, 1, w, 0, 0, 4'h0, 4'h0, 30'h0, 1, jsp, 4'h0);
    endtask

    task automatic peek_ptr(int w, int exp, string name);
        dvstack_wid = NW_WIDTH'(w);
        #1 chk(name, dvstack_ptr, exp);
    endtask

    initial begin
        int toks [8] = '{3, 3, 2, 2, 1, 1, 0, 0};
        int w, jsp;
        for (int i = 0; i < NUM_WARPS; i++) m_ptr[i] = 0;
        e_ovf = 0; e_unf = 0;
        @(negedge clk);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1, 4'h3, 4'hC, 30'h55, 0, 0, 4'hF);
        chk("reset_tmask_valid", tmask_upd_valid, 0);
        peek_ptr(1, 0, "reset_ptr");

        split(1, 1, 4'b1111, 4'b0011, 4'b1100, 30'h104);
        chk("lit_split_mask", tmask_upd_mask, 4'b0011);
        peek_ptr(1, 1, "lit_split_ptr");
        joinc(1, 0);
        chk("lit_join1_mask", tmask_upd_mask, 4'b1100);
        chk("lit_join1_pc", branch_pc, 30'h104);
        peek_ptr(1, 1, "lit_join1_ptr");
        joinc(1, 0);
        chk("lit_join2_mask", tmask_upd_mask, 4'b1111);
        chk("lit_join2_nobr", branch_valid, 0);
        peek_ptr(1, 0, "lit_join2_ptr");

        split(1, 0, 4'hF, 4'h3, 4'hC, 30'h200);
        chk("lit_nodvg_split", tmask_upd_valid, 0);
        joinc(1, 0);
        chk("lit_nodvg_join", tmask_upd_valid, 0);

        for (int i = 0; i < 4; i++)
            split(2, 1, 4'(4'hF >> i), 4'(1 << i), 4'(4'hE >> i), 30'(30'h300 + i));
        split(2, 1, 4'h1, 4'h1, 4'h2, 30'h3FF);
        chk("lit_ovf", ovf_err, 1);
        chk("lit_ovf_noupd", tmask_upd_valid, 0);
        peek_ptr(2, 4, "lit_ovf_ptr");
        for (int i = 0; i < 8; i++) joinc(2, toks[i]);
        chk("lit_unwind_mask", tmask_upd_mask, 4'hF);
        peek_ptr(2, 0, "lit_unwind_ptr");

        joinc(3, 0);
        chk("lit_join0_nounf", unf_err, 0);
        joinc(3, 2);
        chk("lit_unf", unf_err, 1);

        split(1, 1, 4'hF, 4'h5, 4'hA, 30'h40);
        step(1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        peek_ptr(1, 0, "lit_mid_reset_ptr");
        chk("lit_mid_reset_ovf", ovf_err, 0);
        chk("lit_mid_reset_unf", unf_err, 0);
        chk("lit_mid_reset_upd", tmask_upd_valid, 0);

        for (int n = 0; n < 600; n++) begin
            w = $urandom_range(0, NUM_WARPS - 1);
            jsp = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : $urandom_range(0, m_ptr[w]);
            step($urandom_range(0, 79) == 0, $urandom_range(0, 9) != 0, w,
                 $urandom_range(0, 1), $urandom_range(0, 3) != 0,
                 4'($urandom), 4'($urandom), 30'($urandom),
                 $urandom_range(0, 1), jsp, 4'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vx_dvstack_ctl.md
Name: vx_dvstack_ctl

Overview:
- Warp-control consumer for split/join: per-warp divergence (IPDOM) stack manager on the scheduler side of the warp-control interface.
- Accepts split and join commands from the SFU warp-control unit.
- Returns the current stack pointer for the issuing warp. The SFU writes that value to rd as the split token.
- Issues thread-mask updates and PC redirects to the warp scheduler.

Parameters:
NUM_WARPS, 4, number of warps; NW_WIDTH = UP(CLOG2(NUM_WARPS))
NUM_THREADS, 4, threads per warp (mask width)
PC_BITS, 30, width of word-aligned PC
DEPTH, 4, stack entries per warp; DV_STACK_SIZEW = CLOG2(DEPTH+1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ctl_valid  in  1  warp-control command valid (one-cycle pulse, no backpressure)
ctl_wid  in  NW_WIDTH  target warp
split_valid  in  1  command is split
split_is_dvg  in  1  split diverges (then and else masks both non-zero)
split_then_tmask  in  NUM_THREADS  mask to run first
split_else_tmask  in  NUM_THREADS  mask deferred
split_next_pc  in  PC_BITS  PC of the deferred path
join_valid  in  1  command is join
join_stack_ptr  in  DV_STACK_SIZEW  token captured at the matching split
cur_tmask  in  NUM_THREADS  scheduler's current mask for ctl_wid
dvstack_wid  in  NW_WIDTH  query warp
dvstack_ptr  out  DV_STACK_SIZEW  current stack pointer of dvstack_wid (combinational)
tmask_upd_valid  out  1  mask update strobe
tmask_upd_wid  out  NW_WIDTH  warp to update
tmask_upd_mask  out  NUM_THREADS  new thread mask
branch_valid  out  1  PC redirect strobe
branch_wid  out  NW_WIDTH  warp to redirect
branch_pc  out  PC_BITS  redirect target
ovf_err  out  1  sticky overflow flag
unf_err  out  1  sticky underflow flag

Behaviour:
- State per warp:
  - ptr[w], DV_STACK_SIZEW bits.
  - DEPTH entries of {orig_tmask, else_tmask, else_pc, else_done}.
  - Stored in flops or an async-read RAM.
- Reset: all ptr=0, else_done=0, all outputs 0, ovf_err=unf_err=0. A command in the reset cycle is dropped.
- dvstack_ptr = ptr[dvstack_wid]: purely combinational and reflects committed state. The SFU samples it in the same cycle it issues the split, so the token is the pre-push value.
- Latency: state commits at the clock edge of the ctl_valid cycle. tmask_upd_* and branch_* are registered and appear exactly 1 cycle later, as 1-cycle pulses.
- Back-to-back commands to the same warp in consecutive cycles must see the prior update, because reads use committed state.
- Split, is_dvg=0: no push, no outputs.
- Split, is_dvg=1, ptr<DEPTH:
  - entry[ptr] <= {cur_tmask, split_else_tmask, split_next_pc, 0}
  - ptr++
  - tmask_upd with split_then_tmask
- Split, is_dvg=1, ptr==DEPTH: no push, no output, ovf_err<=1.
- Join, join_stack_ptr==ptr: non-divergent join; no-op.
- Join, ptr>join_stack_ptr, top = entry[ptr-1]:
  - else_done=0: set else_done=1; tmask_upd with top.else_tmask; branch with top.else_pc, same cycle as tmask_upd.
  - else_done=1: ptr--; tmask_upd with top.orig_tmask; no branch.
- Join with ptr==0 and join_stack_ptr!=0, or join_stack_ptr>ptr: no-op, unf_err<=1.
- split_valid and join_valid both set: split wins. The join is ignored and flagged through unf_err.
- ctl_valid=0, or neither valid bit set: no state change.
- Outputs for different warps in consecutive cycles are independent; no merging.

Decomposition:
- Shared package:
  - dvstack_entry_t {orig_tmask, else_tmask, else_pc, else_done}
  - DV_STACK_SIZEW
  - split_t and join_t (already shared with the SFU)
- Sub-module vx_dvstack_bank: one warp's stack.
  - Holds storage, ptr, push and toggle/pop ports, and top read.
  - Instantiated NUM_WARPS times.
  - The top level decodes commands and registers outputs.

Test Plan:
- Divergent split: w1, cur_tmask=4'b1111, then=4'b0011, else=4'b1100, next_pc=0x104.
  - dvstack_ptr(w1)=0 before the edge, 1 after.
  - tmask_upd w1=4'b0011 one cycle later.
- Join with token 0 on the above: tmask_upd=4'b1100 and branch_pc=0x104 one cycle later; ptr stays 1.
- Second join with token 0: tmask_upd=4'b1111, no branch; ptr returns to 0.
- Non-divergent split (is_dvg=0) then join with token 0: no outputs, ptr stays 0.
- Nested splits: 4 divergent splits on w2 with DEPTH=4, then a 5th split.
  - 5th split: no push, no output, ovf_err=1, ptr stays 4.
  - 8 joins with tokens 3,3,2,2,1,1,0,0 unwind to ptr=0; masks restore in LIFO order.
- Boundary cases:
  - Join with token 0 on w3 at ptr=0: no-op.
  - Join with token 2 on w3 at ptr=0: unf_err=1.
  - Reset asserted mid-sequence on w1 (ptr=1): ptr=0, flags and outputs 0 the next cycle.
